// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, and feeds decode
// through an output register backed by a one-entry skid buffer.
module fetch_stage #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic                   fd_valid_o,
    output logic [INSTR_WIDTH-1:0] fd_instr_o,
    output logic [ADDR_WIDTH-1:0]  fd_pc_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } fd_entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, req_pc_q;
    logic                  fd_valid_q, buf_valid_q;
    fd_entry_t             fd_q, buf_q, rsp_entry;
    logic                  req_fire, rsp_live;
    logic                  unused_redirect_lsbs;

    // Redirect targets are word aligned; the low bits carry no information.
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign req_fire  = imem_req_valid_o && imem_req_ready_i;
    assign rsp_live  = (state_q == WAIT) && imem_rsp_valid_i && !flush_i;
    assign rsp_entry = '{instr: imem_rsp_data_i, pc: req_pc_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = WAIT;
            // A response arriving with a flush is dropped immediately, nothing left to drain.
            WAIT:    if (imem_rsp_valid_i) state_d = IDLE;
                     else if (flush_i)     state_d = DRAIN;
            DRAIN:   if (imem_rsp_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid_o = (state_q == IDLE) && !rst_i && !flush_i && !buf_valid_q;
        imem_addr_o      = pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= BOOT_ADDR;
            req_pc_q <= '0;
        end else if (flush_i) begin
            pc_q <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (req_fire) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + ADDR_WIDTH'(4);
        end
    end

    // A stall only holds a valid instruction; an empty register may still take a response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fd_valid_q  <= 1'b0;
            fd_q        <= '0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else if (flush_i) begin
            fd_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
        end else if (stall_i && fd_valid_q) begin
            if (rsp_live) begin
                buf_valid_q <= 1'b1;
                buf_q       <= rsp_entry;
            end
        end else if (buf_valid_q) begin
            fd_valid_q  <= 1'b1;
            fd_q        <= buf_q;
            buf_valid_q <= 1'b0;
        end else if (rsp_live) begin
            fd_valid_q <= 1'b1;
            fd_q       <= rsp_entry;
        end else begin
            fd_valid_q <= 1'b0;
        end
    end

    assign fd_valid_o = fd_valid_q;
    assign fd_instr_o = fd_q.instr;
    assign fd_pc_o    = fd_q.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan scenarios with literal checks, then random traffic
// against a queue-based model of the delivered instruction stream.
module tb_fetch_stage;
    localparam logic [31:0] BOOT = 32'h100;

    logic        clk = 1'b0;
    logic        rst, stall, flush, req_ready, rsp_valid;
    logic        req_valid, fd_valid;
    logic [31:0] redir, addr, rsp_data, fd_instr, fd_pc;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .BOOT_ADDR(BOOT)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .redirect_pc_i(redir),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .fd_valid_o(fd_valid), .fd_instr_o(fd_instr), .fd_pc_o(fd_pc)
    );

    int tests = 0, fails = 0;
    int lat = 1;

    // memory environment
    bit mem_pend = 0;
    int mem_cnt  = 0;

    // model: pc, one outstanding request (possibly stale), queue of instructions owed to decode
    bit          m_init = 0, m_os = 0, m_stale = 0;
    logic [31:0] m_pc, m_os_pc;
    logic [31:0] qi[$], qp[$];

    // mid-cycle observations for literal checks
    logic        o_req_v, o_fd_v;
    logic [31:0] o_addr, o_fd_pc, o_fd_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        bit exp_req, hs;
        rsp_valid = 1'b0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = $urandom;
            end
        end
        @(negedge clk);
        o_req_v = req_valid; o_addr = addr; o_fd_v = fd_valid; o_fd_pc = fd_pc; o_fd_instr = fd_instr;
        exp_req = !rst && !flush && !m_os && (qp.size() < 2);
        if (m_init) begin
            chk("req_valid", req_valid, exp_req);
            if (exp_req) chk("req_addr", addr, m_pc);
            chk("fd_valid", fd_valid, qp.size() > 0);
            if (qp.size() > 0) begin
                chk("fd_pc", fd_pc, qp[0]);
                chk("fd_instr", fd_instr, qi[0]);
            end
        end else if (rst) begin
            chk("req_valid_in_rst", req_valid, 0);
        end
        hs = req_valid && req_ready;
        @(posedge clk);
        if (rst) mem_pend = 0;
        else begin
            if (rsp_valid) mem_pend = 0;
            if (hs) begin mem_pend = 1; mem_cnt = lat; end
        end
        if (rst) begin
            m_init = 1; m_pc = BOOT; m_os = 0; m_stale = 0;
            qi.delete(); qp.delete();
        end else if (m_init) begin
            if (flush) begin
                qi.delete(); qp.delete();
                m_pc = {redir[31:2], 2'b00};
                if (m_os) begin
                    if (rsp_valid) begin m_os = 0; m_stale = 0; end
                    else m_stale = 1;
                end
            end else begin
                if (!stall && qp.size() > 0) begin
                    void'(qi.pop_front());
                    void'(qp.pop_front());
                end
                if (m_os && rsp_valid) begin
                    if (!m_stale) begin qi.push_back(rsp_data); qp.push_back(m_os_pc); end
                    m_os = 0; m_stale = 0;
                end
                if (exp_req && req_ready) begin
                    m_os = 1; m_os_pc = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; redir = '0; req_ready = 1; rsp_valid = 0; rsp_data = '0;
        @(posedge clk); #1;
        tick();
        tick();
        chk("rst_fd_valid", o_fd_v, 0); chk("rst_fd_instr", o_fd_instr, 0);
        chk("rst_fd_pc", o_fd_pc, 0);   chk("rst_req_valid", o_req_v, 0);

        // streaming from BOOT_ADDR, latency 1
        rst = 0; lat = 1;
        tick(); chk("boot_req", o_req_v, 1); chk("boot_addr", o_addr, 32'h100);
        tick(); tick(); chk("s0_valid", o_fd_v, 1); chk("s0_pc", o_fd_pc, 32'h100);
        tick(); tick(); chk("s1_pc", o_fd_pc, 32'h104);
        tick(); stall = 1;
        tick(); chk("s2_pc", o_fd_pc, 32'h108);

        // 5-cycle stall while the 0x10C response lands in the skid buffer
        tick();
        tick(); chk("skid_no_req", o_req_v, 0); chk("skid_hold_pc", o_fd_pc, 32'h108);
        tick(); tick(); chk("skid_hold_pc2", o_fd_pc, 32'h108);
        stall = 0;
        tick(); chk("skid_no_req2", o_req_v, 0);
        tick(); chk("skid_out_v", o_fd_v, 1); chk("skid_out_pc", o_fd_pc, 32'h10C);
        chk("resume_addr", o_addr, 32'h110);
        tick(); lat = 3;
        tick(); chk("resume_pc", o_fd_pc, 32'h110);

        // flush in WAIT with the response two cycles away
        flush = 1; redir = 32'h200;
        tick();
        flush = 0;
        tick(); chk("drain_no_req", o_req_v, 0); chk("drain_fd_v", o_fd_v, 0);
        tick(); chk("drop_fd_v", o_fd_v, 0);
        lat = 1;
        tick(); chk("redir_addr", o_addr, 32'h200);

        // flush with response and stall in the same cycle; wraparound target
        flush = 1; stall = 1; redir = 32'hFFFFFFFC;
        tick();
        flush = 0; stall = 0;
        tick(); chk("wrap_addr0", o_addr, 32'hFFFFFFFC); chk("wrap_fd_v", o_fd_v, 0);
        tick(); tick(); chk("wrap_addr1", o_addr, 32'h0); chk("wrap_fd_pc", o_fd_pc, 32'hFFFFFFFC);

        // unaligned redirect
        flush = 1; redir = 32'h203;
        tick();
        flush = 0; lat = 2;
        tick(); chk("align_addr", o_addr, 32'h200);

        // reset while WAIT with a valid output
        tick(); tick();
        stall = 1; lat = 3;
        tick(); chk("pre_rst_v", o_fd_v, 1); chk("pre_rst_pc", o_fd_pc, 32'h200);
        tick(); chk("pre_rst_hold", o_fd_v, 1);
        rst = 1;
        tick();
        tick(); chk("post_rst_fd_v", o_fd_v, 0); chk("post_rst_req", o_req_v, 0);
        rst = 0; stall = 0;
        tick(); chk("post_rst_req_v", o_req_v, 1); chk("post_rst_addr", o_addr, BOOT);

        // random traffic against the model
        repeat (3000) begin
            rst       = ($urandom % 300 == 0);
            stall     = ($urandom % 4 == 0);
            flush     = ($urandom % 12 == 0);
            redir     = ($urandom % 8 == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
            req_ready = ($urandom % 4 != 0);
            lat       = $urandom_range(1, 3);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
